// File: rtl/lab4cpu_pio_pkg.sv
// Shared register map and edge-type codes for the lab4 CPU PIO ports.
// Imported by the switch input PIO and the LED output PIO.
package lab4cpu_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lab4cpu_sync_edge_detect.sv
// Input synchronizer chain followed by a one-clock-delayed sample
// and a per-bit edge detector.
module lab4cpu_sync_edge_detect
    import lab4cpu_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edges
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
            prev <= '0;
        end else begin
            stage[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            prev <= stage[SYNC_STAGES-1];
        end
    end

    assign sync = stage[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

    always_comb begin
        edges = rise;
        if (EDGE_TYPE == EDGE_FALL) begin
            edges = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edges = rise | fall;
        end
    end

endmodule

// File: rtl/lab4cpu_switch_input.sv
// Avalon-MM input PIO: synchronized switch data, sticky edge capture
// with write-1-to-clear, and a masked level interrupt.
module lab4cpu_switch_input
    import lab4cpu_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic             unused_wdata;

    lab4cpu_sync_edge_detect #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync    (sync),
        .edges   (edges)
    );

    assign wr_en = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        w1c = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            w1c = writedata[WIDTH-1:0];
        end
    end

    // A fresh edge is OR-ed in after the clear so it is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irqmask      <= '0;
            irq          <= 1'b0;
        end else begin
            edge_capture <= (edge_capture & ~w1c) | edges;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_capture & irqmask);
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lab4cpu_switch_input.sv
// Bench for lab4cpu_switch_input: two instances (8-bit rising,
// 4-bit any-edge) against an input-history model.
module tb_lab4cpu_switch_input;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in0;
    logic [3:0]  in1;
    logic [31:0] readdata0;
    logic [31:0] readdata1;
    logic        irq0;
    logic        irq1;

    int total = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lab4cpu_switch_input #(
        .WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in0),
        .readdata(readdata0), .irq(irq0)
    );

    lab4cpu_switch_input #(
        .WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in1),
        .readdata(readdata1), .irq(irq1)
    );

    // Model: a = input at last edge, b = one edge older (visible
    // data), c = two edges older (previous sample).
    logic [31:0] ma [2];
    logic [31:0] mb [2];
    logic [31:0] mc [2];
    logic [31:0] mcap [2];
    logic [31:0] mmask [2];
    logic        mirq [2];

    function automatic logic [31:0] wmask(int i);
        return (i == 0) ? 32'hFF : 32'hF;
    endfunction

    function automatic logic [31:0] in_val(int i);
        return (i == 0) ? {24'b0, in0} : {28'b0, in1};
    endfunction

    function automatic logic [31:0] edge_of(int i, logic [31:0] s,
                                            logic [31:0] p);
        if (i == 0) return s & ~p;
        return s ^ p;
    endfunction

    function automatic logic [31:0] clr_of(int i);
        if (chipselect && !write_n && address == 2'd3)
            return writedata & wmask(i);
        return 32'h0;
    endfunction

    function automatic logic [31:0] mread(int i, logic [1:0] a);
        case (a)
            2'd0: return mb[i];
            2'd2: return mmask[i];
            2'd3: return mcap[i];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                ma[i] <= 0; mb[i] <= 0; mc[i] <= 0;
                mcap[i] <= 0; mmask[i] <= 0; mirq[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mcap[i] <= (mcap[i] & ~clr_of(i))
                         | edge_of(i, mb[i], mc[i]);
                mirq[i] <= |(mcap[i] & mmask[i]);
                if (chipselect && !write_n && address == 2'd2)
                    mmask[i] <= writedata & wmask(i);
                mc[i] <= mb[i];
                mb[i] <= ma[i];
                ma[i] <= in_val(i);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h t=%0t",
                     nm, got, exp, $time);
        end else begin
            passed++;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("model_rd0", readdata0, mread(0, address));
            chk("model_irq0", {31'b0, irq0}, {31'b0, mirq[0]});
            chk("model_rd1", readdata1, mread(1, address));
            chk("model_irq1", {31'b0, irq1}, {31'b0, mirq[1]});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b0;
        writedata = d;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input string nm, input int i,
                      input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(nm, (i == 0) ? readdata0 : readdata1, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        address = 2'd0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = 32'h0;
        in0 = 8'h00;
        in1 = 4'h0;
        #12;
        reset_n = 1'b1;
        in0 = 8'hA5;

        tick();
        rd("sync_lat_e1", 0, 2'd0, 32'h0);
        tick();
        rd("sync_lat_e2", 0, 2'd0, 32'hA5);
        wr(2'd0, 32'hFF);
        rd("data_wr_ignored", 0, 2'd0, 32'hA5);
        rd("cap_first_rise", 0, 2'd3, 32'hA5);
        wr(2'd3, 32'hFF);
        rd("cap_cleared", 0, 2'd3, 32'h0);

        wr(2'd2, 32'h01);
        rd("mask_rd", 0, 2'd2, 32'h01);
        in0 = 8'hA4;
        tick(4);
        rd("fall_no_cap", 0, 2'd3, 32'h0);
        in0 = 8'hA5;
        tick(2);
        rd("cap_not_yet", 0, 2'd3, 32'h0);
        tick();
        rd("cap_bit0", 0, 2'd3, 32'h01);
        chk("irq_not_yet", {31'b0, irq0}, 32'h0);
        tick();
        chk("irq_rise", {31'b0, irq0}, 32'h1);

        in0 = 8'h25;
        tick(3);
        in0 = 8'hA5;
        tick(3);
        rd("cap_81", 0, 2'd3, 32'h81);
        wr(2'd3, 32'h01);
        rd("w1c_bit0", 0, 2'd3, 32'h80);
        chk("irq_lag_hi", {31'b0, irq0}, 32'h1);
        tick();
        chk("irq_fall", {31'b0, irq0}, 32'h0);
        wr(2'd2, 32'h80);
        chk("irq_lag_lo", {31'b0, irq0}, 32'h0);
        tick();
        chk("irq_rerise", {31'b0, irq0}, 32'h1);

        in0 = 8'hA1;
        tick(3);
        in0 = 8'hA5;
        tick(2);
        wr(2'd3, 32'h84);
        rd("set_wins", 0, 2'd3, 32'h04);

        wr(2'd2, 32'hFF);
        tick();
        chk("irq_pre_reset", {31'b0, irq0}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_irq", {31'b0, irq0}, 32'h0);
        rd("rst_mask", 0, 2'd2, 32'h0);
        rd("rst_cap", 0, 2'd3, 32'h0);
        #2;
        reset_n = 1'b1;
        tick(2);
        rd("rel_no_cap", 0, 2'd3, 32'h0);
        tick();
        rd("rel_held_high", 0, 2'd3, 32'hA5);
        wr(2'd3, 32'hFF);

        in1 = 4'h8;
        tick(3);
        rd("any_rise", 1, 2'd3, 32'h8);
        wr(2'd3, 32'h8);
        rd("any_clr", 1, 2'd3, 32'h0);
        in1 = 4'h0;
        tick(3);
        rd("any_fall", 1, 2'd3, 32'h8);
        in1 = 4'hF;
        tick(2);
        rd("w4_data", 1, 2'd0, 32'hF);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0)
                in0 = in0 ^ 8'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0)
                in1 = in1 ^ 4'($urandom);
            address = 2'($urandom);
            chipselect = ($urandom_range(0, 2) == 0);
            write_n = $urandom_range(0, 1) == 1;
            writedata = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #1;
                chk("rnd_rst_irq0", {31'b0, irq0}, 32'h0);
                chk("rnd_rst_rd0", readdata0, 32'h0);
                chk("rnd_rst_rd1", readdata1, 32'h0);
                #4;
                reset_n = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lab4cpu_switch_input.md
Name: lab4cpu_switch_input

Overview:
Avalon-MM slave input PIO. It is the read-side counterpart of the CPU's LED output port. It samples an external WIDTH-bit input bus (slide switches / pushbuttons) through a synchronizer and captures edges in a sticky register. It raises a level interrupt to the Nios II CPU when a captured edge is unmasked. It sits on the CPU data master's interconnect beside the LED output PIO.

Parameters:
WIDTH, 8, number of input bits (1..32)
EDGE_TYPE, 0, edge to capture: 0 rising, 1 falling, 2 any
SYNC_STAGES, 2, synchronizer depth (2..3) ahead of the edge-detect flop

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
address  input  2  word address of register within slave
chipselect  input  1  slave selected this cycle
write_n  input  1  active-low write strobe
writedata  input  32  write data
in_port  input  WIDTH  asynchronous external input bus
readdata  output  32  read data, zero-extended; combinational (0 wait states, 0 read latency)
irq  output  1  level interrupt to CPU, active high

Behaviour:
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous and active-low. All flops clear immediately on reset_n=0.
- Reset values: sync chain 0, prev-sample flop 0, irqmask 0, edge_capture 0, irq 0, readdata 0 for every address.
- Synchronizer:
  - in_port passes through SYNC_STAGES flops; sync = last stage.
  - prev = sync delayed one clk.
  - An in_port change that is stable before edge k appears in sync after edge k+SYNC_STAGES-1.
- Edge detect (combinational, per bit):
  - rise = sync & ~prev
  - fall = ~sync & prev
  - edge = rise, fall, or rise|fall per EDGE_TYPE
- Register map (word addresses):
  - 0 DATA: read returns sync zero-extended; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQMASK: R/W; bits [WIDTH-1:0] writable; upper bits read 0.
  - 3 EDGECAP: read returns edge_capture. Write clears each bit whose writedata bit is 1 (write-1-to-clear); 0 bits are unaffected.
- Write qualifier: chipselect && ~write_n. A write with chipselect=0 has no effect.
- Edge capture, per bit each clk:
  - edge=1 sets the bit.
  - A W1C on that bit clears it.
  - Simultaneous edge and W1C on the same bit: set wins; the new edge is never lost.
- irq = |(edge_capture & irqmask), registered. It rises one clk after the capture bit/mask condition is true and falls one clk after the condition clears.
- readdata is driven regardless of chipselect; the interconnect qualifies reads.
- Reset release: sync and prev start at 0. An input held high through reset is therefore seen as a rising edge SYNC_STAGES+1 edges after release. This is intentional; software clears EDGECAP at init.
- Reset mid-operation: all state clears. Pending captures and irq are dropped with no glitch beyond the async clear.
- Glitch filtering: none. Pulses shorter than one clk may be missed. This is accepted; debouncing is software's job.

Decomposition:
- Shared package lab4cpu_pio_pkg:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY
  - the LED output PIO also imports ADDR_DATA
- One sub-module, lab4cpu_sync_edge_detect:
  - parameterised WIDTH, SYNC_STAGES, EDGE_TYPE
  - outputs sync[WIDTH-1:0] and edge[WIDTH-1:0]
  - the top holds the register file, capture logic and irq

Test Plan:
- Reset: assert reset_n=0 mid-clock with irqmask=0xFF and edge_capture=0x0F -> irq and all registers 0 immediately; read addr 2 and 3 return 0x00000000.
- Data sync latency (SYNC_STAGES=2): in_port 0x00->0xA5 before edge 1 -> addr 0 reads 0x00 after edge 1 and 0x000000A5 after edge 2; write 0xFF to addr 0 has no effect.
- Rising capture and irq: irqmask=0x01; in_port bit0 0->1 -> EDGECAP=0x01 after edge 3, irq=1 after edge 4; in_port bit0 1->0 -> no new capture (EDGE_TYPE=0).
- W1C and mask: EDGECAP=0x81; write 0x01 to addr 3 -> EDGECAP=0x80; with irqmask=0x01, irq falls one clk later; write 0x80 to addr 2 -> irq rises again.
- Simultaneous set/clear: W1C of bit 2 on the same edge bit 2 sees a new rising edge -> bit 2 remains 1; bits cleared in the same write without an edge go to 0.
- EDGE_ANY and width: WIDTH=4, EDGE_TYPE=2; toggle in_port bit3 0->1->0 with a W1C between -> captured both times; reads of addr 0 and 3 have bits [31:4]=0.
